// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray-count receiver.
// Conversions operate on a fixed maximum width; narrower values are zero-extended.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros leave the prefix XOR unchanged, so this works for any width up to the maximum.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop clock-domain-crossing synchronizer for a Gray-coded bus.
// Kept as its own module so CDC timing constraints can target its instance.
module sync_ff #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_cnt_rx.sv
// Receives a Gray-coded count from a foreign clock domain and turns each count
// step into one event, handed out through a valid/ready interface with a saturating backlog.
module gray_cnt_rx
    import gray_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] gray_in,
    input  logic         ev_ready,
    input  logic         clr_ovf,
    output logic         ev_valid,
    output logic [W-1:0] cnt_out,
    output logic [W-1:0] pending,
    output logic         ovf
);

    logic [W-1:0] sync_q;
    logic [W-1:0] bin;
    logic [W-1:0] delta;
    logic [W:0]   pend_sum;
    logic         sat;
    logic         consume;

    rx_state_t    state_q, state_d;
    logic [2:0]   fill_q, fill_d;
    logic         fill_done;
    logic         run_en;
    logic [W-1:0] cnt_q;
    logic [W-1:0] last_q, last_d;
    logic [W-1:0] pend_q, pend_d;
    logic         ovf_q, ovf_d;

    sync_ff #(
        .W      (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (sync_q)
    );

    assign bin       = W'(gray2bin(GRAY_MAX_W'(sync_q)));
    assign fill_done = (fill_q == 3'(SYNC_STAGES));

    // Modular subtraction absorbs source wrap-around; bit W of the sum flags saturation.
    assign delta    = bin - last_q;
    assign consume  = ev_valid & ev_ready;
    assign pend_sum = {1'b0, pend_q} + {1'b0, delta} - (W+1)'(consume);
    assign sat      = pend_sum[W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_done) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        run_en   = (state_q == RUN);
        ev_valid = (state_q == RUN) && (pend_q != '0);
    end

    always_comb begin
        fill_d = fill_q;
        last_d = last_q;
        pend_d = pend_q;
        ovf_d  = ovf_q & ~clr_ovf;
        if (!run_en) begin
            if (!fill_done) begin
                fill_d = 3'(fill_q + 3'd1);
            end else begin
                last_d = bin;
            end
        end else begin
            last_d = bin;
            pend_d = sat ? '1 : pend_sum[W-1:0];
            // A new overflow outranks a simultaneous clear.
            if (sat) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            cnt_q  <= bin;
            last_q <= last_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt_out = cnt_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_gray_cnt_rx.sv
// Directed and randomized bench for gray_cnt_rx, an 8-bit and a 4-bit instance sharing one clock.
module tb_gray_cnt_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, rdy8, clr8, v8, ovf8;
    logic [7:0] g8, cnt8, pend8;
    logic       rst4, rdy4, clr4, v4, ovf4;
    logic [3:0] g4, cnt4, pend4;

    int checks   = 0;
    int failures = 0;
    int acc      = 0;
    int steps    = 0;
    int src8     = 0;
    int src4     = 0;

    gray_cnt_rx #(.W(8), .SYNC_STAGES(2)) dut8 (
        .clk (clk), .rst (rst8), .gray_in (g8), .ev_ready (rdy8), .clr_ovf (clr8),
        .ev_valid (v8), .cnt_out (cnt8), .pending (pend8), .ovf (ovf8)
    );

    gray_cnt_rx #(.W(4), .SYNC_STAGES(2)) dut4 (
        .clk (clk), .rst (rst4), .gray_in (g4), .ev_ready (rdy4), .clr_ovf (clr4),
        .ev_valid (v4), .cnt_out (cnt4), .pending (pend4), .ovf (ovf4)
    );

    function automatic logic [7:0] gray8(input int b);
        logic [7:0] v;
        v = 8'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge; a handshake seen here is taken at the next rising edge.
    task automatic tick();
        if (v8 && rdy8) acc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic step8();
        src8 = (src8 + 1) % 256;
        g8   = gray8(src8);
        ticks(4);
    endtask

    task automatic step4();
        src4 = (src4 + 1) % 16;
        g4   = gray4(src4);
        ticks(4);
    endtask

    initial begin
        rst8 = 1'b1; rdy8 = 1'b0; clr8 = 1'b0; src8 = 37; g8 = gray8(37);
        rst4 = 1'b1; rdy4 = 1'b0; clr4 = 1'b0; src4 = 0;  g4 = gray4(0);
        @(negedge clk);
        tick();
        chk("rst_cnt", 32'(cnt8), 32'(0));
        chk("rst_pend", 32'(pend8), 32'(0));
        chk("rst_valid", 32'(v8), 32'(0));
        chk("rst_ovf", 32'(ovf8), 32'(0));
        rst8 = 1'b0;
        rst4 = 1'b0;

        // Decode latency and spurious-event-free baseline after reset
        ticks(2);
        chk("lat_early", 32'(cnt8), 32'(0));
        tick();
        chk("lat_cnt37", 32'(cnt8), 32'(37));
        for (int i = 0; i < 10; i++) begin
            chk("hold_idle", {30'd0, v8, 1'b0} | 32'(pend8), 32'(0));
            tick();
        end

        // Five slow increments drained immediately
        rdy8 = 1'b1;
        acc  = 0;
        repeat (5) step8();
        ticks(8);
        chk("inc5_acc", 32'(acc), 32'(5));
        chk("inc5_pend", 32'(pend8), 32'(0));
        chk("inc5_ovf", 32'(ovf8), 32'(0));
        chk("inc5_cnt", 32'(cnt8), 32'(42));

        // Wrap-around FC -> 03 with consumer stalled, then burst drain
        rdy8 = 1'b0;
        src8 = 252;
        g8   = gray8(src8);
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        ticks(8);
        chk("wrap_base", 32'(pend8), 32'(0));
        repeat (7) step8();
        ticks(4);
        chk("wrap_pend", 32'(pend8), 32'(7));
        chk("wrap_cnt", 32'(cnt8), 32'(3));
        rdy8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("drain_valid", 32'(v8), 32'(1));
            tick();
            chk("drain_pend", 32'(pend8), 32'(6 - i));
        end
        rdy8 = 1'b0;
        chk("drain_done", 32'(v8), 32'(0));

        // Delta and accept landing on the same edge
        repeat (3) step8();
        ticks(4);
        chk("sim_pre3", 32'(pend8), 32'(3));
        src8 = (src8 + 1) % 256;
        g8   = gray8(src8);
        tick();
        tick();
        chk("sim_before", 32'(pend8), 32'(3));
        rdy8 = 1'b1;
        tick();
        rdy8 = 1'b0;
        chk("sim_both", 32'(pend8), 32'(3));
        ticks(4);
        chk("sim_stable", 32'(pend8), 32'(3));

        // Reset mid-operation discards backlog; ready during the empty window is harmless
        repeat (6) step8();
        ticks(4);
        chk("rst9_pre", 32'(pend8), 32'(9));
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        rdy8 = 1'b1;
        chk("rst9_pend", 32'(pend8), 32'(0));
        for (int i = 0; i < 8; i++) begin
            chk("rst9_valid", 32'(v8), 32'(0));
            tick();
        end
        rdy8 = 1'b0;
        chk("rst9_after", 32'(pend8), 32'(0));
        chk("rst9_ovf", 32'(ovf8), 32'(0));
        chk("rst9_cnt", 32'(cnt8), 32'(src8));

        // Randomized traffic: backlog must equal source steps minus accepted events
        acc   = 0;
        steps = 0;
        for (int r = 0; r < 10; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int s = 0; s < n; s++) begin
                int gap;
                src8 = (src8 + 1) % 256;
                g8   = gray8(src8);
                steps++;
                gap = int'($urandom_range(1, 5));
                for (int c = 0; c < gap; c++) begin
                    rdy8 = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            rdy8 = 1'b0;
            ticks(6);
            chk("rand_backlog", 32'(pend8), 32'(steps - acc));
            chk("rand_valid", 32'(v8), 32'(steps != acc));
        end
        rdy8 = 1'b1;
        ticks(100);
        rdy8 = 1'b0;
        chk("rand_total", 32'(acc), 32'(steps));
        chk("rand_pend0", 32'(pend8), 32'(0));
        chk("rand_cnt", 32'(cnt8), 32'(src8));
        chk("rand_ovf", 32'(ovf8), 32'(0));

        // 4-bit instance: saturation, sticky flag, clear, and set-over-clear priority
        repeat (20) step4();
        ticks(4);
        chk("w4_pend_sat", 32'(pend4), 32'(15));
        chk("w4_ovf_set", 32'(ovf4), 32'(1));
        chk("w4_cnt", 32'(cnt4), 32'(src4));
        ticks(3);
        chk("w4_ovf_sticky", 32'(ovf4), 32'(1));
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("w4_ovf_clr", 32'(ovf4), 32'(0));
        chk("w4_pend_kept", 32'(pend4), 32'(15));
        src4 = (src4 + 1) % 16;
        g4   = gray4(src4);
        tick();
        tick();
        chk("w4_pre_set", 32'(ovf4), 32'(0));
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("w4_set_wins", 32'(ovf4), 32'(1));
        chk("w4_pend_still", 32'(pend4), 32'(15));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
